// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Imem_ready qualifies Imem_data for the Imem_addr presented in the same cycle.
interface fetch_stage_if;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic        Imem_ready;
    logic [31:0] Imem_data;

    modport master (output Imem_req, output Imem_addr, input Imem_ready, input Imem_data);
    modport slave  (input Imem_req, input Imem_addr, output Imem_ready, output Imem_data);
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, next-PC select, imem handshake with one-entry hold buffer, IF/ID register.
// Optional saturating perf counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_Stall,
    input  logic        IF_ID_Flush,
    input  logic        BranchOrnot,
    input  logic [31:0] Branch_target,
    input  logic        IsJump,
    input  logic [31:0] Jump_target,
    fetch_stage_if.master imem,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_PC_plus4,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic [31:0] Stall_cycles,
    output logic [31:0] Flush_count,
    output logic [31:0] Imem_wait_cycles,
    output logic        fsm_state
);

    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      state;
    logic [31:0] buf_pc_plus4;
    logic [31:0] buf_instr;

    logic        redirect_r;
    logic        stall_s;
    logic        jump_j;
    logic        redirect;
    logic        flush_ack;
    logic        kill;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    // Branch in EX outranks the stall; a stalled jump waits and re-presents later.
    assign redirect_r = BranchOrnot;
    assign stall_s    = EX_Stall & ~BranchOrnot;
    assign jump_j     = IsJump & ~stall_s;
    assign redirect   = redirect_r | jump_j;
    assign flush_ack  = IF_ID_Flush & redirect;
    assign kill       = redirect | flush_ack;
    assign target     = redirect_r ? Branch_target : Jump_target;
    assign pc_plus4   = PC + 32'd4;

    assign imem.Imem_req  = (state == FETCH);
    assign imem.Imem_addr = PC;
    assign fsm_state      = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= FETCH;
            PC                <= RESET_PC;
            IF_ID_Instruction <= NOP_INSTR;
            IF_ID_PC_plus4    <= 32'd0;
            IF_ID_Valid       <= 1'b0;
            buf_pc_plus4      <= 32'd0;
            buf_instr         <= NOP_INSTR;
        end else begin
            unique case (state)
                FETCH: begin
                    if (kill) begin
                        PC                <= target;
                        IF_ID_Instruction <= NOP_INSTR;
                        IF_ID_Valid       <= 1'b0;
                    end else if (stall_s) begin
                        // IF/ID frozen; park an arriving word so the request is not lost.
                        if (imem.Imem_ready) begin
                            buf_pc_plus4 <= pc_plus4;
                            buf_instr    <= imem.Imem_data;
                            state        <= HOLD;
                        end
                    end else if (imem.Imem_ready) begin
                        IF_ID_Instruction <= imem.Imem_data;
                        IF_ID_PC_plus4    <= pc_plus4;
                        IF_ID_Valid       <= 1'b1;
                        PC                <= pc_plus4;
                    end else begin
                        IF_ID_Instruction <= NOP_INSTR;
                        IF_ID_Valid       <= 1'b0;
                    end
                end
                HOLD: begin
                    if (kill) begin
                        PC                <= target;
                        IF_ID_Instruction <= NOP_INSTR;
                        IF_ID_Valid       <= 1'b0;
                        state             <= FETCH;
                    end else if (!stall_s) begin
                        IF_ID_Instruction <= buf_instr;
                        IF_ID_PC_plus4    <= buf_pc_plus4;
                        IF_ID_Valid       <= 1'b1;
                        PC                <= pc_plus4;
                        state             <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
            wait_cnt  <= 32'd0;
        end else begin
            if (stall_s && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
            if (redirect && flush_cnt != 32'hFFFF_FFFF)
                flush_cnt <= flush_cnt + 32'd1;
            if (state == FETCH && !imem.Imem_ready && !redirect && wait_cnt != 32'hFFFF_FFFF)
                wait_cnt <= wait_cnt + 32'd1;
        end
    end

    assign Stall_cycles     = stall_cnt;
    assign Flush_count      = flush_cnt;
    assign Imem_wait_cycles = wait_cnt;
`else
    assign Stall_cycles     = 32'd0;
    assign Flush_count      = 32'd0;
    assign Imem_wait_cycles = 32'd0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline: the PC register, next-PC selection, instruction-memory request handshake and the IF/ID pipeline register. It is the direct consumer of the hazard unit's EX_Stall and IF_ID_Flush outputs. It takes branch targets resolved in EX and jump targets resolved in ID. It absorbs a variable-latency instruction memory with a one-entry hold buffer.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on bubble or flush (sll $0,$0,0).

Ports:
clk  input  1  pipeline clock.
reset  input  1  synchronous, active-high reset.
EX_Stall  input  1  load-use stall from hazard unit; hold PC and IF/ID.
IF_ID_Flush  input  1  flush IF/ID (branch taken or jump).
BranchOrnot  input  1  branch in EX taken.
Branch_target  input  32  target for a taken branch.
IsJump  input  1  j/jal/jr decoded in ID.
Jump_target  input  32  resolved jump target (j/jal/jr).
Imem_req  output  1  fetch request.
Imem_addr  output  32  fetch address (= PC).
Imem_ready  input  1  Imem_data valid for the Imem_addr presented this cycle.
Imem_data  input  32  instruction word.
PC  output  32  current fetch PC.
IF_ID_PC_plus4  output  32  PC+4 of the instruction in IF/ID.
IF_ID_Instruction  output  32  instruction in IF/ID.
IF_ID_Valid  output  1  IF/ID holds a real instruction.
Stall_cycles  output  32  perf counter (see Optional Feature).
Flush_count  output  32  perf counter.
Imem_wait_cycles  output  32  perf counter.

Behaviour:
- Reset (sync, any state, including mid-request or in HOLD): PC<=RESET_PC, state<=FETCH, buffer invalid, IF_ID_Instruction<=NOP_INSTR, IF_ID_PC_plus4<=0, IF_ID_Valid<=0. Counters are cleared. Imem_req reads 1 in the first cycle after reset.
- Event priority, highest first:
  1. reset.
  2. Redirect R = BranchOrnot. Target is Branch_target.
  3. Stall S = EX_Stall & ~BranchOrnot.
  4. Jump J = IsJump & ~S. Target is Jump_target.
  5. Normal flow.
- IF_ID_Flush is honoured only when R or J is true. When S is true, IsJump and IF_ID_Flush are ignored; the jump re-presents after the stall clears.
- Imem_addr = PC combinationally. Imem_req = 1 in FETCH and 0 in HOLD.
- FETCH state:
  - R or J: PC<=target. IF/ID<=bubble (NOP_INSTR, Valid 0). Any Imem_data this cycle is discarded. Stay in FETCH.
  - Else S: IF/ID held. If Imem_ready, buffer<={PC+4, Imem_data} and go to HOLD. PC is unchanged.
  - Else if Imem_ready: IF/ID<={PC+4, Imem_data, Valid 1}. PC<=PC+4.
  - Else (memory wait): IF/ID<=bubble. PC unchanged.
- HOLD state:
  - R or J: buffer dropped. PC<=target. IF/ID<=bubble. Go to FETCH.
  - Else S: hold everything.
  - Else: IF/ID<=buffer (Valid 1). PC<=PC+4. Go to FETCH.
- Latency: with Imem_ready constantly 1 and no hazards, one instruction enters IF/ID per cycle. PC-to-IF/ID latency is 1 cycle.
- PC+4 is a 32-bit add that wraps at 2^32, with no trap. Targets are taken verbatim; the low 2 bits are not checked.
- Redirect uses targets sampled in the same cycle as BranchOrnot or IsJump.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: three 32-bit saturating counters, cleared on reset.
  - Stall_cycles increments each cycle S is true.
  - Flush_count increments each cycle R or J is true.
  - Imem_wait_cycles increments each FETCH cycle with Imem_req=1, Imem_ready=0 and no redirect.
  - Each counter holds at 32'hFFFF_FFFF.
- Undefined: the three outputs are tied to 0 and no counter flops are inferred. Ports remain present.

Test Plan:
- Reset then Imem_ready=1 with data 0x20080001, 0x20090002, 0x01095020 → PC steps 0x00400000, 0x00400004, 0x00400008. IF/ID shows each word one cycle later with PC_plus4 0x00400004, 0x00400008, 0x0040000C and Valid=1.
- EX_Stall=1 for 2 cycles while Imem_ready=1 at PC 0x00400008 → IF/ID holds the previous instruction. State goes to HOLD with Imem_req=0. On release, IF/ID gets the buffered word and PC becomes 0x0040000C.
- BranchOrnot=1, Branch_target=0x00400040, with EX_Stall=1 and IsJump=1 in the same cycle → next PC=0x00400040, IF/ID is NOP with Valid 0, and the jump is ignored.
- IsJump=1, Jump_target=0x00400100 while Imem_ready=0 (wait state) → PC=0x00400100, IF/ID bubble. A late ready for 0x00400004 is not captured.
- IsJump=1 with EX_Stall=1 → PC and IF/ID unchanged. After EX_Stall drops with IsJump still 1, PC=Jump_target.
- Reset asserted while in HOLD with the buffer valid → next cycle PC=RESET_PC, Valid=0, Imem_req=1 and counters=0. With FETCH_PERF_CNT_EN, after a 3-cycle stall Stall_cycles=3.
